// File: rtl/dwc_stim_sequencer.sv
// Stimulus sequencer for the DWC checker: loads one word as both operands, runs the
// load/set handshake, supplies an LFSR fault mask and keeps pass/fail statistics.
module dwc_stim_sequencer #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        inject_en,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic        data_set_a,
  output logic        data_set_b,
  output logic        dwc_enable,
  output logic        error_enable,
  output logic [31:0] lfsr_mask,
  input  logic        done,
  input  logic        match,
  output logic        res_valid,
  output logic        res_match,
  output logic        res_injected,
  output logic        busy,
  output logic [15:0] ok_count,
  output logic [15:0] err_count,
  output logic        timeout_flag
);

  localparam logic [31:0]   SEED_EFF = (LFSR_SEED == '0) ? 32'h1 : LFSR_SEED;
  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_SET_A, S_LOAD_B, S_SET_B, S_WAIT, S_REPORT, S_RELEASE
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   word_q;
  logic [31:0]   lfsr_q;
  logic [31:0]   lfsr_nx;
  logic [TW-1:0] timer_q;
  logic          match_q;
  logic          timed_out_q;
  logic          accept;
  logic          timer_last;

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = in_valid & in_ready;
  assign timer_last = (timer_q == T_LAST);
  assign lfsr_mask  = lfsr_q;
  assign lfsr_nx    = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (accept) state_nx = S_LOAD_A;
      S_LOAD_A:  state_nx = S_SET_A;
      S_SET_A:   state_nx = S_LOAD_B;
      S_LOAD_B:  state_nx = S_SET_B;
      S_SET_B:   state_nx = S_WAIT;
      S_WAIT:    if (done || timer_last) state_nx = S_REPORT;
      S_REPORT:  state_nx = S_RELEASE;
      S_RELEASE: if (!done || timer_last) state_nx = S_IDLE;
    endcase
  end

  // Each state's actions land on the edge that leaves it, so outputs trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q       <= '0;
      lfsr_q       <= SEED_EFF;
      timer_q      <= '0;
      match_q      <= 1'b0;
      timed_out_q  <= 1'b0;
      data_a       <= '0;
      data_b       <= '0;
      data_set_a   <= 1'b0;
      data_set_b   <= 1'b0;
      dwc_enable   <= 1'b0;
      error_enable <= 1'b0;
      res_valid    <= 1'b0;
      res_match    <= 1'b0;
      res_injected <= 1'b0;
      ok_count     <= '0;
      err_count    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            word_q       <= in_data;
            error_enable <= inject_en;
            lfsr_q       <= lfsr_nx;
            timer_q      <= '0;
            match_q      <= 1'b0;
            timed_out_q  <= 1'b0;
          end
        end
        S_LOAD_A: begin
          data_a     <= word_q;
          dwc_enable <= 1'b1;
        end
        S_SET_A:  data_set_a <= 1'b1;
        S_LOAD_B: data_b     <= word_q;
        S_SET_B:  data_set_b <= 1'b1;
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (done)            match_q     <= match;
          else if (timer_last) timed_out_q <= 1'b1;
        end
        S_REPORT: begin
          data_set_a   <= 1'b0;
          data_set_b   <= 1'b0;
          res_valid    <= 1'b1;
          res_match    <= match_q & ~timed_out_q;
          res_injected <= error_enable;
          timer_q      <= '0;
        end
        S_RELEASE: begin
          dwc_enable <= 1'b0;
          if (!done || timer_last) error_enable <= 1'b0;
          else                     timer_q      <= timer_q + TW'(1);
        end
      endcase

      if (clear) begin
        ok_count     <= '0;
        err_count    <= '0;
        timeout_flag <= 1'b0;
      end else begin
        if (state == S_REPORT) begin
          if (match_q && !timed_out_q) begin
            if (ok_count != '1) ok_count <= ok_count + 16'd1;
          end else begin
            if (err_count != '1) err_count <= err_count + 16'd1;
          end
          if (timed_out_q) timeout_flag <= 1'b1;
        end
        if (state == S_RELEASE && done && timer_last) timeout_flag <= 1'b1;
      end
    end
  end

endmodule
